lzx_seg7_reader: RTL and testbench

Recovers the 4-bit hex code from a 7-segment drive bus (a..g, active-high, the same segment encoding our hex-to-7-segment decoders produce) and delivers each new stable value over a valid/ready handshake. It sits on the observation side of a display path: self-checking benches, scan-chain readback or loopback checks of decoder outputs. A stability filter rejects glitches while the bus settles. Blank and illegal patterns are reported separately.

---
 rtl/lzx_seg7_reader_if.sv | 28 ++
 rtl/lzx_seg7_reader.sv | 144 ++++++++++++++
 tb/tb_lzx_seg7_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lzx_seg7_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : lzx_seg7_reader_if
// Description : Segment bus input plus valid/ready result channel of the
//               7-segment reader. The master drives the segment bus and the
//               ready; the slave (the reader) presents decoded values.
// Revision    : 1.0 - initial release
// ============================================================================
interface lzx_seg7_reader_if;
    logic [6:0] seg;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_code;
    logic       out_blank;
    logic       out_err;
    logic [7:0] err_cnt;

    modport master (
        output seg, out_ready,
        input  out_valid, out_code, out_blank, out_err, err_cnt
    );

    modport slave (
        input  seg, out_ready,
        output out_valid, out_code, out_blank, out_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lzx_seg7_reader.sv
`default_nettype none
// ============================================================================
// Module      : lzx_seg7_reader
// Description : Recovers the hex code from a 7-segment drive bus. A run-length
//               stability filter accepts a pattern once it has been seen on
//               STABLE_CYC consecutive samples and differs from the last
//               accepted pattern; the result is held on a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module lzx_seg7_reader #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    lzx_seg7_reader_if.slave   bus
);

    localparam logic [7:0] c_RUN_MAX = 8'(STABLE_CYC);
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_load;

    logic [6:0] r_samp;
    logic [7:0] r_run;
    logic [6:0] r_last;
    logic       r_last_vld;

    logic [3:0] r_code;
    logic       r_blank;
    logic       r_err;
    logic [7:0] r_err_cnt;

    logic       w_hit;
    logic [3:0] w_code;
    logic       w_stable_new;

    // Input register and run-length counter of identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= 7'd0;
            r_run  <= 8'd0;
        end else begin
            r_samp <= bus.seg;
            if (bus.seg != r_samp) begin
                r_run <= 8'd1;
            end else if (r_run != c_RUN_MAX) begin
                r_run <= r_run + 8'd1;
            end
        end
    end

    // Reverse glyph lookup of the settled sample.
    always_comb begin
        w_hit  = 1'b1;
        w_code = 4'h0;
        case (r_samp)
            7'h7E: w_code = 4'h0;
            7'h30: w_code = 4'h1;
            7'h6D: w_code = 4'h2;
            7'h79: w_code = 4'h3;
            7'h33: w_code = 4'h4;
            7'h5B: w_code = 4'h5;
            7'h5F: w_code = 4'h6;
            7'h70: w_code = 4'h7;
            7'h7F: w_code = 4'h8;
            7'h7B: w_code = 4'h9;
            7'h77: w_code = 4'hA;
            7'h1F: w_code = 4'hB;
            7'h4E: w_code = 4'hC;
            7'h3D: w_code = 4'hD;
            7'h4F: w_code = 4'hE;
            7'h47: w_code = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // A settled pattern is a candidate only if it is new since the last accept.
    assign w_stable_new = (r_run == c_RUN_MAX) && (!r_last_vld || (r_samp != r_last));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TRACK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and accept strobe; acceptance is only possible in TRACK.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_TRACK: begin
                if (w_stable_new) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_TRACK;
                end
            end
            default: w_state_nxt = ST_TRACK;
        endcase
    end

    // Result registers, last-accepted memory and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code     <= 4'h0;
            r_blank    <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_last     <= 7'd0;
            r_last_vld <= 1'b0;
        end else if (w_load) begin
            r_code     <= w_code;
            r_blank    <= (r_samp == 7'd0);
            r_err      <= !w_hit && (r_samp != 7'd0);
            r_last     <= r_samp;
            r_last_vld <= 1'b1;
            if (!w_hit && (r_samp != 7'd0) && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_code  = r_code;
    assign bus.out_blank = r_blank;
    assign bus.out_err   = r_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lzx_seg7_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lzx_seg7_reader
// Description : Self-checking bench for lzx_seg7_reader. Directed scenarios
//               plus random segment traffic, compared every cycle against a
//               window-based reference model of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lzx_seg7_reader;

    localparam int S = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lzx_seg7_reader_if bus ();

    lzx_seg7_reader #(.STABLE_CYC(S)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [6:0] hq[$];
    bit         m_valid;
    logic [6:0] m_pat;
    logic [6:0] m_last;
    bit         m_last_vld;
    int         m_cnt;

    // transfers observed on the DUT: {err, blank, code}
    logic [5:0] xq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int glyph_idx(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (GLYPH[i] == p) return i;
        return -1;
    endfunction

    // true when the last S samples are all the same pattern
    function automatic bit stable_now();
        if (hq.size() < S) return 1'b0;
        for (int i = 1; i < S; i++)
            if (hq[hq.size()-1-i] != hq[hq.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hq.delete();
        m_valid    = 1'b0;
        m_pat      = 7'd0;
        m_last     = 7'd0;
        m_last_vld = 1'b0;
        m_cnt      = 0;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic r);
        bit acc;
        acc = !m_valid && stable_now() && (!m_last_vld || (hq[hq.size()-1] != m_last));
        if (m_valid && r) m_valid = 1'b0;
        if (acc) begin
            m_valid    = 1'b1;
            m_pat      = hq[hq.size()-1];
            m_last     = m_pat;
            m_last_vld = 1'b1;
            if (glyph_idx(m_pat) < 0 && m_pat != 7'd0 && m_cnt < 255) m_cnt++;
        end
        hq.push_back(s);
        if (hq.size() > 16) void'(hq.pop_front());
    endtask

    task automatic check_outputs();
        int idx;
        chk("valid", bus.out_valid, m_valid);
        if (m_valid) begin
            idx = glyph_idx(m_pat);
            chk("code",  bus.out_code, (idx >= 0) ? idx : 0);
            chk("blank", bus.out_blank, m_pat == 7'd0);
            chk("err",   bus.out_err, (idx < 0) && (m_pat != 7'd0));
        end
        chk("err_cnt", bus.err_cnt, m_cnt);
    endtask

    // one clock: check, drive, clock edge, update model; ends just after negedge
    task automatic cyc(input logic [6:0] s, input logic r);
        check_outputs();
        bus.seg       = s;
        bus.out_ready = r;
        if (bus.out_valid && r) xq.push_back({bus.out_err, bus.out_blank, bus.out_code});
        @(posedge clk);
        model_edge(s, r);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] s, input logic r, input int n);
        for (int i = 0; i < n; i++) cyc(s, r);
    endtask

    initial begin
        int base;
        int lat;
        logic [6:0] p;
        logic [6:0] prev;

        rst_n         = 1'b0;
        bus.seg       = 7'd0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_code",  bus.out_code, 4'h0);
        chk("rst_blank", bus.out_blank, 1'b0);
        chk("rst_err",   bus.out_err, 1'b0);
        chk("rst_cnt",   bus.err_cnt, 8'd0);
        rst_n = 1'b1;

        // single glyph: latency and one-shot transfer
        base = xq.size();
        for (int i = 1; i <= 12; i++) begin
            cyc(7'h6D, 1'b1);
            if (i == 4) chk("lat_e4", bus.out_valid, 1'b0);
            if (i == 5) chk("lat_e5", bus.out_valid, 1'b1);
            if (i == 6) chk("lat_e6", bus.out_valid, 1'b0);
        end
        chk("a_nx", xq.size() - base, 1);
        chk("a_code", xq[base], 6'h02);

        // sweep all glyphs, then blank
        base = xq.size();
        for (int g = 0; g < 16; g++) hold(GLYPH[g], 1'b1, 6);
        hold(7'h00, 1'b1, 6);
        chk("sweep_nx", xq.size() - base, 17);
        if (xq.size() - base == 17) begin
            for (int g = 0; g < 16; g++) chk($sformatf("sweep%0d", g), xq[base+g], {2'b00, 4'(g)});
            chk("sweep_blank", xq[base+16], 6'b010000);
        end

        // glitch then return to the accepted glyph
        base = xq.size();
        hold(7'h30, 1'b1, 6);
        hold(7'h7E, 1'b1, 2);
        hold(7'h30, 1'b1, 8);
        chk("glitch_nx", xq.size() - base, 1);
        chk("glitch_code", xq[base], 6'h01);

        // backpressure: intermediate glyph dropped
        base = xq.size();
        hold(7'h79, 1'b0, 6);
        hold(7'h33, 1'b0, 6);
        hold(7'h5B, 1'b0, 6);
        hold(7'h5B, 1'b1, 8);
        chk("bp_nx", xq.size() - base, 2);
        chk("bp_first", xq[base], 6'h03);
        chk("bp_second", xq[base+1], 6'h05);

        // illegal patterns and counter saturation
        base = xq.size();
        hold(7'h01, 1'b1, 6);
        hold(7'h02, 1'b1, 6);
        chk("ill_nx", xq.size() - base, 2);
        chk("ill_x0", xq[base], 6'b100000);
        chk("ill_x1", xq[base+1], 6'b100000);
        chk("ill_cnt2", bus.err_cnt, 8'd2);
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h01 : 7'h02, 1'b1, 6);
        chk("ill_sat", bus.err_cnt, 8'd255);

        // reset while a value is pending
        hold(7'h4E, 1'b0, 8);
        chk("hold_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", bus.out_valid, 1'b0);
        chk("mid_code",  bus.out_code, 4'h0);
        chk("mid_err",   bus.out_err, 1'b0);
        chk("mid_blank", bus.out_blank, 1'b0);
        chk("mid_cnt",   bus.err_cnt, 8'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(7'h4E, 1'b0);
            if (bus.out_valid && lat < 0) lat = i;
        end
        chk("rerelease_lat", lat, S + 1);
        hold(7'h4E, 1'b1, 2);

        // random traffic
        prev = 7'h4E;
        for (int k = 0; k < 400; k++) begin
            int sel;
            int n;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                p = GLYPH[$urandom_range(0, 15)];
            end else if (sel == 6) begin
                p = 7'h00;
            end else if (sel == 7) begin
                p = 7'($urandom_range(1, 127));
                while (glyph_idx(p) >= 0) p = 7'($urandom_range(1, 127));
            end else begin
                p = prev;
            end
            prev = p;
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) cyc(p, $urandom_range(0, 3) != 0);
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
